// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous instruction
// memory, and forms the IF/ID boundary with a one-bubble redirect squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_f;
  logic [31:0] id_pc_r;
  logic        id_valid_r;
  logic [31:0] fetch_count_r;
  logic [29:0] sel_word;
  logic [31:0] target;
  logic        redirect;

  // While stalled the ID instruction is re-read so imem_instr keeps showing it.
  assign sel_word    = stall ? id_pc_r[31:2] : pc_f[31:2];
  assign imem_addr   = {2'b00, sel_word};

  assign id_valid    = id_valid_r;
  assign id_instr    = id_valid_r ? imem_instr : 32'h0;
  assign id_pc       = id_pc_r;
  assign id_pc_plus4 = id_pc_r + 32'd4;
  assign fetch_count = fetch_count_r;

  assign redirect = id_valid_r & ~stall & (jr | jump | branch_taken);

  // Later assignments override earlier ones, giving jr > jump > branch.
  always_comb begin
    // NOTE: default first so every path assigns target and no latch is inferred.
    target = id_pc_plus4 + (branch_offset << 2);
    if (jump) target = {id_pc_plus4[31:28], jump_index, 2'b00};
    if (jr)   target = jr_target & ~32'h3;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f          <= RESET_PC;
      id_pc_r       <= 32'h0;
      id_valid_r    <= 1'b0;
      fetch_count_r <= 32'h0;
    end else if (!stall) begin
      if (id_valid_r) fetch_count_r <= fetch_count_r + 32'd1;
      id_pc_r <= pc_f;
      if (redirect) begin
        // The instruction fetched this cycle is squashed: one bubble.
        pc_f       <= target;
        id_valid_r <= 1'b0;
      end else begin
        pc_f       <= pc_f + 32'd4;
        id_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a synchronous instruction memory model
// plus hand-computed expectations for each scenario.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a scrambled function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) imem_instr <= mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
    jump = 1'b0; jump_index = 26'h0; jr = 1'b0; jr_target = 32'h0;
    #1;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want %h", imem_addr, 32'h0); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", id_instr); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", id_pc); end
    n_checks++; if (id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4: got %h want 4", id_pc_plus4); end
    n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %h want 0", fetch_count); end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (imem_addr !== 32'(k)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", k, imem_addr, 32'(k)); end
      if (k > 0) begin
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", k, id_valid); end
        n_checks++; if (id_pc !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", k, id_pc, 32'(4 * (k - 1))); end
        n_checks++; if (id_instr !== mem_word(32'(k - 1))) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", k, id_instr, mem_word(32'(k - 1))); end
        n_checks++; if (fetch_count !== 32'(k - 1)) begin n_fail++; $display("FAIL seq_count[%0d]: got %h want %h", k, fetch_count, 32'(k - 1)); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (imem_addr !== 32'd2) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 2", i, imem_addr); end
      n_checks++; if (id_pc !== 32'd8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 8", i, id_pc); end
      n_checks++; if (id_instr !== mem_word(32'd2)) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, id_instr, mem_word(32'd2)); end
      n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d]: got %h want 2", i, fetch_count); end
      tick();
    end
    stall = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'd3) begin n_fail++; $display("FAIL stall_rel_addr: got %h want 3", imem_addr); end
    n_checks++; if (id_pc !== 32'd8) begin n_fail++; $display("FAIL stall_rel_pc: got %h want 8", id_pc); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'd12) begin n_fail++; $display("FAIL stall_after_pc1: got %h want 12", id_pc); end
    n_checks++; if (id_instr !== mem_word(32'd3)) begin n_fail++; $display("FAIL stall_after_instr1: got %h want %h", id_instr, mem_word(32'd3)); end
    n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL stall_after_count1: got %h want 3", fetch_count); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'd16) begin n_fail++; $display("FAIL stall_after_pc2: got %h want 16", id_pc); end
    n_checks++; if (id_instr !== mem_word(32'd4)) begin n_fail++; $display("FAIL stall_after_instr2: got %h want %h", id_instr, mem_word(32'd4)); end
    n_checks++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL stall_after_count2: got %h want 4", fetch_count); end
  endtask

  task automatic test_branch();
    apply_reset();
    tick();
    tick();
    branch_taken = 1'b1; branch_offset = 32'd3;
    #1;
    n_checks++; if (id_pc !== 32'd4) begin n_fail++; $display("FAIL br_at_pc: got %h want 4", id_pc); end
    tick();
    branch_taken = 1'b0;
    // Redirect requests during the bubble must be ignored.
    jr = 1'b1; jr_target = 32'h0000_0100;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble_valid: got %b want 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL br_bubble_instr: got %h want 0", id_instr); end
    n_checks++; if (imem_addr !== 32'd5) begin n_fail++; $display("FAIL br_bubble_addr: got %h want 5", imem_addr); end
    n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL br_bubble_count: got %h want 2", fetch_count); end
    tick();
    jr = 1'b0;
    #1;
    n_checks++; if (id_pc !== 32'd20) begin n_fail++; $display("FAIL br_target_pc: got %h want 20", id_pc); end
    n_checks++; if (id_instr !== mem_word(32'd5)) begin n_fail++; $display("FAIL br_target_instr: got %h want %h", id_instr, mem_word(32'd5)); end
    n_checks++; if (imem_addr !== 32'd6) begin n_fail++; $display("FAIL br_ignored_jr_addr: got %h want 6", imem_addr); end
    n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL br_target_count: got %h want 2", fetch_count); end
    // Backward branch: 24 + (-5 << 2) = 4.
    branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFB;
    tick();
    branch_taken = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'd1) begin n_fail++; $display("FAIL br_neg_addr: got %h want 1", imem_addr); end
    n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL br_neg_count: got %h want 3", fetch_count); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'd4) begin n_fail++; $display("FAIL br_neg_pc: got %h want 4", id_pc); end
    n_checks++; if (id_instr !== mem_word(32'd1)) begin n_fail++; $display("FAIL br_neg_instr: got %h want %h", id_instr, mem_word(32'd1)); end
  endtask

  task automatic test_jumps();
    apply_reset();
    tick();
    jr = 1'b1; jr_target = 32'h1000_0010;
    tick();
    jr = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h0400_0004) begin n_fail++; $display("FAIL jr_setup_addr: got %h want %h", imem_addr, 32'h0400_0004); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'h1000_0010) begin n_fail++; $display("FAIL jr_setup_pc: got %h want %h", id_pc, 32'h1000_0010); end
    n_checks++; if (id_pc_plus4 !== 32'h1000_0014) begin n_fail++; $display("FAIL jr_setup_pc4: got %h want %h", id_pc_plus4, 32'h1000_0014); end
    jump = 1'b1; jump_index = 26'h40; jr = 1'b1; jr_target = 32'h0000_0023;
    tick();
    jump = 1'b0; jr = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'd8) begin n_fail++; $display("FAIL jr_wins_addr: got %h want 8", imem_addr); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL jr_wins_valid: got %b want 0", id_valid); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'h20) begin n_fail++; $display("FAIL jr_wins_pc: got %h want 20", id_pc); end
    n_checks++; if (id_instr !== mem_word(32'd8)) begin n_fail++; $display("FAIL jr_wins_instr: got %h want %h", id_instr, mem_word(32'd8)); end
    jr = 1'b1; jr_target = 32'h1000_0010;
    tick();
    jr = 1'b0;
    tick();
    #1;
    n_checks++; if (id_pc !== 32'h1000_0010) begin n_fail++; $display("FAIL j_setup_pc: got %h want %h", id_pc, 32'h1000_0010); end
    jump = 1'b1;
    tick();
    jump = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h0400_0040) begin n_fail++; $display("FAIL j_addr: got %h want %h", imem_addr, 32'h0400_0040); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'h1000_0100) begin n_fail++; $display("FAIL j_pc: got %h want %h", id_pc, 32'h1000_0100); end
    n_checks++; if (id_instr !== mem_word(32'h0400_0040)) begin n_fail++; $display("FAIL j_instr: got %h want %h", id_instr, mem_word(32'h0400_0040)); end
  endtask

  task automatic test_stall_redirect();
    apply_reset();
    tick();
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'd2;
    #1;
    n_checks++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL sr_stall_addr: got %h want 0", imem_addr); end
    n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL sr_stall_count: got %h want 0", fetch_count); end
    tick();
    stall = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL sr_no_redirect_valid: got %b want 1", id_valid); end
    n_checks++; if (id_pc !== 32'd0) begin n_fail++; $display("FAIL sr_no_redirect_pc: got %h want 0", id_pc); end
    n_checks++; if (imem_addr !== 32'd1) begin n_fail++; $display("FAIL sr_no_redirect_addr: got %h want 1", imem_addr); end
    n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL sr_no_redirect_count: got %h want 0", fetch_count); end
    tick();
    branch_taken = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL sr_bubble_valid: got %b want 0", id_valid); end
    n_checks++; if (imem_addr !== 32'd3) begin n_fail++; $display("FAIL sr_bubble_addr: got %h want 3", imem_addr); end
    n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL sr_bubble_count: got %h want 1", fetch_count); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'd12) begin n_fail++; $display("FAIL sr_target_pc: got %h want 12", id_pc); end
    n_checks++; if (id_instr !== mem_word(32'd3)) begin n_fail++; $display("FAIL sr_target_instr: got %h want %h", id_instr, mem_word(32'd3)); end
    n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL sr_target_count: got %h want 1", fetch_count); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'd16) begin n_fail++; $display("FAIL sr_next_pc: got %h want 16", id_pc); end
    n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL sr_next_count: got %h want 2", fetch_count); end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    tick();
    jr = 1'b1; jr_target = 32'hFFFF_FFFF;
    tick();
    jr = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 32'h3FFF_FFFF); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", id_pc, 32'hFFFF_FFFC); end
    n_checks++; if (id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want 0", id_pc_plus4); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 0", imem_addr); end
    tick();
    #1;
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_after_pc: got %h want 0", id_pc); end
    n_checks++; if (id_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL wrap_after_instr: got %h want %h", id_instr, mem_word(32'h0)); end
  endtask

  task automatic test_reset_mid_redirect();
    apply_reset();
    tick();
    tick();
    branch_taken = 1'b1; branch_offset = 32'd3;
    tick();
    branch_taken = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'd5) begin n_fail++; $display("FAIL mid_bubble_addr: got %h want 5", imem_addr); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr: got %h want 0", imem_addr); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", id_valid); end
    n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL mid_rst_count: got %h want 0", fetch_count); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc: got %h want 0", id_pc); end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (imem_addr !== 32'(k)) begin n_fail++; $display("FAIL restart_addr[%0d]: got %h want %h", k, imem_addr, 32'(k)); end
      if (k > 0) begin
        n_checks++; if (id_pc !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL restart_pc[%0d]: got %h want %h", k, id_pc, 32'(4 * (k - 1))); end
        n_checks++; if (id_instr !== mem_word(32'(k - 1))) begin n_fail++; $display("FAIL restart_instr[%0d]: got %h want %h", k, id_instr, mem_word(32'(k - 1))); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jumps();
    test_stall_redirect();
    test_pc_wrap();
    test_reset_mid_redirect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
